time_counter: RTL
=================

// Module: time_counter
// PURPOSE
//  Four-digit BCD MM:SS stopwatch/timer register. It is the consumer end of the loader's per-bit
//  set/reset vectors: set[i] forces count bit i to 1 and reset[i] forces it to 0. Otherwise it
//  counts up or down on a 1 Hz tick under a run/stop FSM. Sits between loader and display decoders.
// PARAMETERS
//  MIN_TENS_MAX  5  upper limit of minutes-tens digit (5 -> max 59:59; 9 -> max 99:59)
// PORTS
//  clk        in   1      system clock; all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  tick       in   1      one-cycle count enable (1 Hz strobe)
//  start      in   1      level/pulse: begin counting
//  stop       in   1      level/pulse: halt counting
//  up_down    in   1      1 = count up, 0 = count down; sampled every tick
//  set        in   16     [16:1] per-bit force-to-1 from loader
//  reset      in   16     [16:1] per-bit force-to-0 from loader
//  count      out  16     [16:1] BCD value: [4:1] s units, [8:5] s tens, [12:9] m units, [16:13] m tens
//  running    out  1      1 in RUN state
//  zero       out  1      count == 00:00 (combinational from count)
//  wrap       out  1      one-cycle pulse on up-count wrap 59:59 -> 00:00
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, state IDLE, running=0, wrap=0; zero=1.
//  - FSM: IDLE --start--> RUN; RUN --stop--> IDLE; RUN --down-count reaches 00:00--> DONE;
//    DONE --start and count!=0--> RUN; any state --load--> stays (load does not change state).
//    start and stop in the same cycle: stop wins.
//  - Load: load = |(set|reset). In a load cycle each bit i becomes reset[i] ? 0 : (set[i] ? 1 : count[i]);
//    reset beats set on the same bit. Counting is suppressed in a load cycle even if tick=1.
//    Update is visible on count the next cycle (1-cycle latency).
//  - Count: in RUN with tick=1 and no load, update the same cycle; new value at the next edge.
//    Digit limits: s units 9, s tens 5, m units 9, m tens MIN_TENS_MAX.
//    Up: digit >= limit -> 0 with carry to the next digit, else +1. At all-max the value wraps to 00:00
//    and wrap pulses for one cycle.
//    Down: digit == 0 -> limit with borrow, digit > limit -> limit (no borrow), else -1.
//    A down-count tick that produces 00:00 moves to DONE. A down tick when already 00:00 (loaded
//    to zero while in RUN) does not change the count and moves to DONE.
//  - Illegal BCD loaded (e.g. s units = 0xC): no error. Up count clamps through the >= limit rule;
//    down count uses the > limit rule.
//  - tick outside RUN: ignored. up_down change mid-run: takes effect on the next tick.
//  - wrap is registered; deasserts the cycle after it pulses. running = (state == RUN).
//  - rst_n asserted mid-count: immediate clear, no pending wrap or DONE survives.
// STRUCTURE
//  - stopwatch_pkg: state enum {IDLE, RUN, DONE}; constants SEC_UNITS_MAX=9, SEC_TENS_MAX=5,
//    MIN_UNITS_MAX=9; BCD digit typedef logic [3:0].
//  - Sub-module bcd_digit #(LIMIT) x4: inputs en, up, cur; outputs nxt, carry/borrow. Combinational
//    next-value only. The top level owns the registers, the load merge and the FSM.
// TESTING
//  1. rst_n=0 mid-run at 12:34 -> count=0000, running=0, zero=1 immediately (async).
//  2. set=16'h0159, reset=16'hFEA6, then start, up_down=1, one tick -> count 01:59 then 02:00.
//  3. Load 59:59, up count, one tick -> 00:00, wrap high exactly 1 cycle, running stays 1.
//  4. Load 00:02, down count, 2 ticks -> 00:01, 00:00, state DONE, running=0, zero=1;
//     further ticks ignored; start with count 0 -> stays DONE.
//  5. Same cycle: tick=1 and set[1]=1, reset[1]=1 on count 00:05 -> count 00:04 (bit cleared,
//     no count step).
//  6. start and stop asserted together in IDLE -> remains IDLE. Load 0x0C (s units 12), up
//     tick -> 00:10.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS BCD stopwatch register.
// Imported by the counter top and its per-digit step logic.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_UNITS_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX  = 4'd5;
  localparam bcd_t MIN_UNITS_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit's combinational up/down step with carry/borrow out.
// Out-of-range digits clamp to LIMIT rather than flagging an error.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t LIMIT = 4'd9
) (
  input  logic en,
  input  logic up,
  input  bcd_t cur,
  output bcd_t nxt,
  output logic co
);

  always_comb begin
    nxt = cur;
    co  = 1'b0;
    if (en) begin
      if (up) begin
        if (cur >= LIMIT) begin
          nxt = 4'd0;
          co  = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == 4'd0) begin
          nxt = LIMIT;
          co  = 1'b1;
        end else if (cur > LIMIT) begin
          nxt = LIMIT;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/time_counter.sv
// Four-digit BCD MM:SS counter with per-bit load merge and run/stop FSM.
// Loader set/reset vectors override counting in the same cycle.
module time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        up_down,
  input  logic [16:1] set,
  input  logic [16:1] reset,
  output logic [16:1] count,
  output logic        running,
  output logic        zero,
  output logic        wrap
);

  localparam bcd_t MIN_TENS_LIM = 4'(MIN_TENS_MAX);

  state_e      state_q, state_d;
  logic [16:1] count_q, count_d;
  logic        wrap_q, wrap_d;
  logic [16:1] step_nxt;
  logic [4:0]  cy;
  logic        load;
  logic        is_zero;
  logic        do_cnt;
  logic        go;

  assign cy[0] = 1'b1;

  bcd_digit #(.LIMIT(SEC_UNITS_MAX)) u_su (
    .en (cy[0]),
    .up (up_down),
    .cur(count_q[4:1]),
    .nxt(step_nxt[4:1]),
    .co (cy[1])
  );

  bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_st (
    .en (cy[1]),
    .up (up_down),
    .cur(count_q[8:5]),
    .nxt(step_nxt[8:5]),
    .co (cy[2])
  );

  bcd_digit #(.LIMIT(MIN_UNITS_MAX)) u_mu (
    .en (cy[2]),
    .up (up_down),
    .cur(count_q[12:9]),
    .nxt(step_nxt[12:9]),
    .co (cy[3])
  );

  bcd_digit #(.LIMIT(MIN_TENS_LIM)) u_mt (
    .en (cy[3]),
    .up (up_down),
    .cur(count_q[16:13]),
    .nxt(step_nxt[16:13]),
    .co (cy[4])
  );

  assign load    = |(set | reset);
  assign is_zero = (count_q == 16'd0);
  assign do_cnt  = (state_q == RUN) && tick && !load;
  assign go      = start && !stop;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (count_q | set) & ~reset;
    end else if (do_cnt) begin
      // A down tick at 00:00 must not borrow round to the max value.
      if (up_down || !is_zero) begin
        count_d = step_nxt;
      end
      wrap_d = up_down && cy[4];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (do_cnt && !up_down &&
                     (is_zero || step_nxt == 16'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (go && !is_zero) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 16'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUN);
  assign zero    = is_zero;
  assign wrap    = wrap_q;

endmodule
